// File: rtl/alu_share_if.sv
// alu_share_if - bundle of every signal between the shared-ALU controller and
// its environment (two requesters, the shared ALU and the response consumer).
//
// Signal groups:
//   req0_*/req1_*  valid/ready request channels: operands a, b and opcode sel
//   alu_*          operands/opcode to the shared ALU, combinational result back
//   rsp_*          valid/ready response channel: id, result, error flag
//
// Modports:
//   master  the controller side (drives ready pulses, ALU inputs, responses)
//   slave   the environment side (requesters, ALU and response consumer)
interface alu_share_if #(
   parameter int DATA_W = 8,
   parameter int RES_W  = 13,
   parameter int SEL_W  = 4
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [SEL_W-1:0]  req0_sel;
   logic              req0_ready;

   logic              req1_valid;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [SEL_W-1:0]  req1_sel;
   logic              req1_ready;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [SEL_W-1:0]  alu_sel;
   logic [RES_W-1:0]  alu_result;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [RES_W-1:0]  rsp_result;
   logic              rsp_err;

   modport master (
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_sel,
      output rsp_valid, rsp_id, rsp_result, rsp_err
   );

   modport slave (
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_sel,
      input  rsp_valid, rsp_id, rsp_result, rsp_err
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl - shares one 8-bit ALU between two requesters.
//
// A round-robin arbiter picks a requester while idle, latches its operands
// and opcode into the registers that drive the shared ALU, captures the
// 13-bit ALU result one cycle later and offers it on a backpressured
// response channel tagged with the requester id. Divide/modulo by zero
// replaces the result with 0 and raises rsp_err.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   alu_share_if.master: request, ALU and response channels
//   busy  high whenever the controller is not idle
//
// Timing: grant (reqN_ready pulse) in cycle T, ALU evaluated in T+1,
// response valid from T+2 until accepted; at most one op per 3 cycles.
module alu_share_ctrl #(
   parameter int DATA_W = 8,
   parameter int RES_W  = 13,
   parameter int SEL_W  = 4
) (
   input  logic        clk,
   input  logic        rst,
   alu_share_if.master bus,
   output logic        busy
);

   localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(3);
   localparam logic [SEL_W-1:0] OP_MOD = SEL_W'(4);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state;
   logic   last_grant;  // id of the most recent grant; the other side wins a tie
   logic   op_id;       // id of the op currently in flight
   logic   grant0;
   logic   grant1;
   logic   div_err;

   // The ready pulse must coincide with the cycle in which the operands are
   // sampled, so the grant is decoded combinationally from the current state
   // and valids rather than registered a cycle early.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && state == IDLE) begin
         grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
         grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // The ALU input registers double as the op registers, so the error test
   // looks at exactly what the ALU is evaluating this cycle.
   assign div_err = (bus.alu_sel == OP_DIV || bus.alu_sel == OP_MOD) &&
                    (bus.alu_b == {DATA_W{1'b0}});

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         op_id          <= 1'b0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_sel    <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_err    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_id       <= grant1;
                  last_grant  <= grant1;
                  bus.alu_a   <= grant1 ? bus.req1_a   : bus.req0_a;
                  bus.alu_b   <= grant1 ? bus.req1_b   : bus.req0_b;
                  bus.alu_sel <= grant1 ? bus.req1_sel : bus.req0_sel;
                  busy        <= 1'b1;
                  state       <= EXEC;
               end
            end

            EXEC: begin
               bus.rsp_id     <= op_id;
               bus.rsp_err    <= div_err;
               bus.rsp_result <= div_err ? {RES_W{1'b0}} : bus.alu_result;
               bus.rsp_valid  <= 1'b1;
               state          <= RESP;
            end

            RESP: begin
               // Response fields simply hold until the consumer takes them.
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end

            default: begin
               bus.rsp_valid <= 1'b0;
               busy          <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule
